fifo4_16: RTL and testbench
===========================

Name: fifo4_16

Overview:
- 4-entry, 16-bit synchronous FIFO.
- Storage is four 16-bit registers; the read side is a 4-way 16-bit word mux whose 2-bit select is the FIFO read pointer.
- Sits directly upstream of the 4-way word-select stage and produces its four data inputs and its select.
- Used to buffer ALU/memory words between producer and consumer stages of the hardware platform.

Parameters:
- WIDTH, 16, data word width in bits. Depth is fixed at 4 entries, so pointers are 2 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- in  input  WIDTH  write data
- push  input  1  write request; sampled on rising clk
- pop  input  1  read request; sampled on rising clk
- out  output  WIDTH  head-of-queue data (show-ahead)
- count  output  3  number of valid entries, 0..4
- full  output  1  high when count == 4
- empty  output  1  high when count == 0
- overflow  output  1  one-cycle pulse: push rejected
- underflow  output  1  one-cycle pulse: pop rejected

Behaviour:
- Reset, sampled on a rising edge:
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0.
  - Storage contents are not cleared.
  - Resulting outputs: empty=1, full=0, out=0.
  - Reset overrides push/pop in the same cycle; a mid-stream reset discards all entries.
- State per cycle:
  - 2-bit wr_ptr, 2-bit rd_ptr, 3-bit count.
  - Pointers wrap 3 -> 0 (modulo-4 arithmetic, carry discarded).
- Effective operations:
  - do_push = push & (!full | pop)
  - do_pop = pop & !empty
- do_push: mem[wr_ptr] <= in; wr_ptr <= wr_ptr+1.
- do_pop: rd_ptr <= rd_ptr+1.
- count update:
  - +1 if do_push & !do_pop
  - -1 if do_pop & !do_push
  - unchanged otherwise
- Simultaneous push+pop:
  - Full: both succeed, count stays 4. The write lands in the slot being vacated (wr_ptr == rd_ptr).
  - Empty: pop is rejected and underflow pulses; push succeeds, count becomes 1.
  - 1..3 entries: both succeed, count unchanged.
- Rejections:
  - push while full without pop: data dropped, state unchanged; overflow=1 for the next cycle only.
  - pop while empty: state unchanged; underflow=1 for the next cycle only.
- Pulse flags are registered and cleared the following cycle unless re-triggered.
- out (combinational):
  - = mem[rd_ptr] through the 4-way word mux (sel = rd_ptr) when !empty; = 0 when empty.
  - A pushed word is visible on out the cycle after the push edge, if the FIFO was empty.
  - Pop latency: the next entry appears on out immediately after the pop edge.
- full/empty are decoded combinationally from the registered count; no glitch-free requirement beyond that.
- No bypass path: a word never appears on out in the same cycle it is presented on in.

Test Plan:
- Reset then idle:
  - reset=1 for 1 cycle -> count=0, empty=1, full=0, out=0, overflow=0, underflow=0.
- Fill and drain order:
  - push 3567, 1095, 25, 1420 on consecutive cycles -> full=1, count=4, out=3567.
  - then pop x4 -> out sequence 1095, 25, 1420, then 0 with empty=1.
- Overflow:
  - when full, push 9999 with pop=0 -> overflow=1 for exactly one cycle, count=4.
  - subsequent pops return 3567, 1095, 25, 1420 (9999 absent).
- Underflow and empty push+pop:
  - when empty, pop -> underflow pulse, count=0.
  - when empty, push 77 + pop together -> underflow pulse, count=1, out=77.
- Wrap-around and full push+pop:
  - push 1,2,3; pop 2; push 4,5,6 -> pointers wrap, count=4.
  - push 7 + pop while full -> count=4, out=4.
  - draining yields 4,5,6,7.
- Reset mid-operation:
  - with count=3, assert reset together with push=1 -> count=0, empty=1, out=0; the pushed word is not stored.

Source files
------------

// File: rtl/fifo4_16_if.sv
// Producer/consumer handshake bundle for the 4-entry word FIFO.
// master drives writes and pops and observes status; slave is the FIFO itself.
interface fifo4_16_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] out;
    logic [2:0]       count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output in, push, pop,
        input  out, count, full, empty, overflow, underflow
    );

    modport slave (
        input  in, push, pop,
        output out, count, full, empty, overflow, underflow
    );
endinterface

// File: rtl/fifo4_16.sv
// 4-entry show-ahead word FIFO; head visible the cycle after the push or pop edge, no bypass.
// Backpressure: push while full without a pop is dropped and pulses overflow; pop while empty pulses underflow.
module fifo4_16 #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    fifo4_16_if.slave   bus
);
    localparam logic [2:0] DEPTH = 3'd4;

    logic [WIDTH-1:0] mem_q [4];
    logic [WIDTH-1:0] mem_d [4];
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] head_word;

    assign full  = (count_q == DEPTH);
    assign empty = (count_q == 3'd0);

    // A pop on a full FIFO frees the slot the push is about to land in.
    assign do_push = bus.push & (~full | bus.pop);
    assign do_pop  = bus.pop & ~empty;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = bus.push & full & ~bus.pop;
        underflow_d = bus.pop & empty;

        if (do_push) begin
            mem_d[wr_ptr_q] = bus.in;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end

        if (do_push && !do_pop) begin
            count_d = count_q + 3'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never cleared; reset only blocks the write that would otherwise land.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        head_word = '0;
        case (rd_ptr_q)
            2'd0:    head_word = mem_q[0];
            2'd1:    head_word = mem_q[1];
            2'd2:    head_word = mem_q[2];
            default: head_word = mem_q[3];
        endcase
    end

    assign bus.out       = empty ? '0 : head_word;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_fifo4_16.sv
// Directed bench for fifo4_16: each scenario task drives vectors and checks hand-computed results.
// Status is compared as {count, full, empty, overflow, underflow} plus the head word.
module tb_fifo4_16;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    fifo4_16_if #(.WIDTH(16)) bus ();

    fifo4_16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, settle past the edge, then release push/pop.
    task automatic cyc(input logic p, input logic q, input logic [15:0] d);
        bus.push = p;
        bus.pop  = q;
        bus.in   = d;
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cyc(1'b0, 1'b0, 16'd0);
        reset = 1'b0;
        n_cmp++;
        if ({bus.count, bus.full, bus.empty, bus.overflow, bus.underflow} !== {3'd0, 4'b0100}) begin
            n_err++;
            $display("FAIL reset_status: got %b want %b",
                     {bus.count, bus.full, bus.empty, bus.overflow, bus.underflow}, {3'd0, 4'b0100});
        end
        n_cmp++;
        if (bus.out !== 16'd0) begin
            n_err++;
            $display("FAIL reset_out: got %0d want 0", bus.out);
        end
    endtask

    task automatic test_fill_drain;
        logic [15:0] fv [4];
        logic [15:0] after_pop [4];
        fv        = '{16'd3567, 16'd1095, 16'd25, 16'd1420};
        after_pop = '{16'd1095, 16'd25, 16'd1420, 16'd0};
        // The first word must not leak onto out before its push edge.
        bus.push = 1'b1;
        bus.in   = fv[0];
        #1;
        n_cmp++;
        if (bus.out !== 16'd0) begin
            n_err++;
            $display("FAIL no_bypass: got %0d want 0", bus.out);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, fv[i]);
            n_cmp++;
            if (bus.count !== 3'(i + 1) || bus.out !== 16'd3567) begin
                n_err++;
                $display("FAIL fill_%0d: got count=%0d out=%0d want count=%0d out=3567",
                         i, bus.count, bus.out, i + 1);
            end
        end
        n_cmp++;
        if ({bus.full, bus.empty} !== 2'b10) begin
            n_err++;
            $display("FAIL fill_full: got full/empty=%b want 10", {bus.full, bus.empty});
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 16'd0);
            n_cmp++;
            if (bus.out !== after_pop[i] || bus.count !== 3'(3 - i)) begin
                n_err++;
                $display("FAIL drain_%0d: got out=%0d count=%0d want out=%0d count=%0d",
                         i, bus.out, bus.count, after_pop[i], 3 - i);
            end
        end
        n_cmp++;
        if ({bus.empty, bus.underflow} !== 2'b10) begin
            n_err++;
            $display("FAIL drain_empty: got empty/underflow=%b want 10", {bus.empty, bus.underflow});
        end
    endtask

    task automatic test_overflow;
        logic [15:0] fv [4];
        fv = '{16'd3567, 16'd1095, 16'd25, 16'd1420};
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, fv[i]);
        cyc(1'b1, 1'b0, 16'd9999);
        n_cmp++;
        if ({bus.count, bus.full, bus.empty, bus.overflow, bus.underflow} !== {3'd4, 4'b1010}
            || bus.out !== 16'd3567) begin
            n_err++;
            $display("FAIL overflow_pulse: got status=%b out=%0d want %b out=3567",
                     {bus.count, bus.full, bus.empty, bus.overflow, bus.underflow}, bus.out,
                     {3'd4, 4'b1010});
        end
        cyc(1'b0, 1'b0, 16'd0);
        n_cmp++;
        if (bus.overflow !== 1'b0 || bus.count !== 3'd4) begin
            n_err++;
            $display("FAIL overflow_clear: got overflow=%b count=%0d want 0 4", bus.overflow, bus.count);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.out !== fv[i]) begin
                n_err++;
                $display("FAIL overflow_order_%0d: got %0d want %0d", i, bus.out, fv[i]);
            end
            cyc(1'b0, 1'b1, 16'd0);
        end
        n_cmp++;
        if (bus.empty !== 1'b1 || bus.out !== 16'd0) begin
            n_err++;
            $display("FAIL overflow_drained: got empty=%b out=%0d want 1 0", bus.empty, bus.out);
        end
    endtask

    task automatic test_underflow;
        cyc(1'b0, 1'b1, 16'd0);
        n_cmp++;
        if ({bus.count, bus.full, bus.empty, bus.overflow, bus.underflow} !== {3'd0, 4'b0101}) begin
            n_err++;
            $display("FAIL underflow_pulse: got %b want %b",
                     {bus.count, bus.full, bus.empty, bus.overflow, bus.underflow}, {3'd0, 4'b0101});
        end
        cyc(1'b0, 1'b0, 16'd0);
        n_cmp++;
        if (bus.underflow !== 1'b0) begin
            n_err++;
            $display("FAIL underflow_clear: got %b want 0", bus.underflow);
        end
        cyc(1'b1, 1'b1, 16'd77);
        n_cmp++;
        if ({bus.count, bus.full, bus.empty, bus.overflow, bus.underflow} !== {3'd1, 4'b0001}
            || bus.out !== 16'd77) begin
            n_err++;
            $display("FAIL empty_push_pop: got status=%b out=%0d want %b out=77",
                     {bus.count, bus.full, bus.empty, bus.overflow, bus.underflow}, bus.out,
                     {3'd1, 4'b0001});
        end
        cyc(1'b0, 1'b1, 16'd0);
        n_cmp++;
        if ({bus.count, bus.empty, bus.underflow} !== {3'd0, 2'b10}) begin
            n_err++;
            $display("FAIL underflow_drain: got count=%0d empty=%b underflow=%b want 0 1 0",
                     bus.count, bus.empty, bus.underflow);
        end
    endtask

    task automatic test_wrap;
        logic [15:0] dv [4];
        dv = '{16'd4, 16'd5, 16'd6, 16'd7};
        cyc(1'b1, 1'b0, 16'd1);
        cyc(1'b1, 1'b0, 16'd2);
        cyc(1'b1, 1'b0, 16'd3);
        cyc(1'b0, 1'b1, 16'd0);
        cyc(1'b0, 1'b1, 16'd0);
        n_cmp++;
        if (bus.count !== 3'd1 || bus.out !== 16'd3) begin
            n_err++;
            $display("FAIL wrap_partial: got count=%0d out=%0d want 1 3", bus.count, bus.out);
        end
        cyc(1'b1, 1'b0, 16'd4);
        cyc(1'b1, 1'b0, 16'd5);
        cyc(1'b1, 1'b0, 16'd6);
        n_cmp++;
        if (bus.count !== 3'd4 || bus.full !== 1'b1 || bus.out !== 16'd3) begin
            n_err++;
            $display("FAIL wrap_full: got count=%0d full=%b out=%0d want 4 1 3",
                     bus.count, bus.full, bus.out);
        end
        cyc(1'b1, 1'b1, 16'd7);
        n_cmp++;
        if ({bus.count, bus.full, bus.empty, bus.overflow, bus.underflow} !== {3'd4, 4'b1000}
            || bus.out !== 16'd4) begin
            n_err++;
            $display("FAIL full_push_pop: got status=%b out=%0d want %b out=4",
                     {bus.count, bus.full, bus.empty, bus.overflow, bus.underflow}, bus.out,
                     {3'd4, 4'b1000});
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.out !== dv[i]) begin
                n_err++;
                $display("FAIL wrap_drain_%0d: got %0d want %0d", i, bus.out, dv[i]);
            end
            cyc(1'b0, 1'b1, 16'd0);
        end
        n_cmp++;
        if (bus.empty !== 1'b1 || bus.out !== 16'd0) begin
            n_err++;
            $display("FAIL wrap_empty: got empty=%b out=%0d want 1 0", bus.empty, bus.out);
        end
    endtask

    task automatic test_mid_reset;
        cyc(1'b1, 1'b0, 16'h00a1);
        cyc(1'b1, 1'b0, 16'h00b2);
        cyc(1'b1, 1'b0, 16'h00c3);
        n_cmp++;
        if (bus.count !== 3'd3 || bus.out !== 16'h00a1) begin
            n_err++;
            $display("FAIL pre_reset: got count=%0d out=%0h want 3 a1", bus.count, bus.out);
        end
        reset = 1'b1;
        cyc(1'b1, 1'b0, 16'hbeef);
        reset = 1'b0;
        n_cmp++;
        if ({bus.count, bus.full, bus.empty, bus.overflow, bus.underflow} !== {3'd0, 4'b0100}
            || bus.out !== 16'd0) begin
            n_err++;
            $display("FAIL mid_reset: got status=%b out=%0h want %b out=0",
                     {bus.count, bus.full, bus.empty, bus.overflow, bus.underflow}, bus.out,
                     {3'd0, 4'b0100});
        end
        cyc(1'b1, 1'b0, 16'h1111);
        n_cmp++;
        if (bus.count !== 3'd1 || bus.out !== 16'h1111) begin
            n_err++;
            $display("FAIL post_reset_push: got count=%0d out=%0h want 1 1111", bus.count, bus.out);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b0;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.in   = 16'd0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_wrap();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
